// File: rtl/uart8_pkg.sv
// Shared constants, FSM state types and baud divider helper for the uart8 receiver/transmitter.

package uart8_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // Integer truncation is intended: the rx divider is allowed to run slightly fast.
   function automatic int baud_div(input int clock_rate, input int baud_rate, input int oversample);
      return clock_rate / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart8_baud_tick.sv
// Free-running clock divider emitting a one-clk tick every DIV clks; clear restarts the count at zero.

module uart8_baud_tick #(
   parameter int DIV = 78
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/uart8_rxtx.sv
// 8N1 UART: 16x oversampling receiver and baud-rate transmitter with independent FSMs.
// Define RX_MAJORITY_VOTE_EN to decide each rx bit by a 2-of-3 vote over samples 6, 7 and 8.

module uart8_rxtx
   import uart8_pkg::*;
#(
   parameter int CLOCK_RATE = 12000000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxEn,
   input  logic       rxIn,
   output logic       rxBusy,
   output logic       rxDone,
   output logic       rxErr,
   output logic [7:0] rxOut,
   input  logic       txEn,
   input  logic       txStart,
   input  logic [7:0] txIn,
   output logic       txBusy,
   output logic       txDone,
   output logic       txOut
);

   localparam int RX_DIV = baud_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
   localparam int TX_DIV = baud_div(CLOCK_RATE, BAUD_RATE, 1);
   localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [3:0] DECIDE_SAMPLE = 4'(MID_SAMPLE + 1);
`else
   localparam logic [3:0] DECIDE_SAMPLE = 4'(MID_SAMPLE);
`endif

   rx_state_t  rx_state, rx_next;
   tx_state_t  tx_state, tx_next;
   logic [1:0] rx_sync;
   logic       line;
   logic       bit_value;
   logic       rx_tick, rx_clear;
   logic       tx_tick, tx_clear;
   logic [3:0] sample_count;
   logic [2:0] bit_index;
   logic [7:0] shadow;
   logic [7:0] rx_out_q;
   logic       rx_done_q, rx_err_q;
   logic [7:0] tx_shift;
   logic [2:0] tx_bit_index;
   logic       tx_done_q;

   uart8_baud_tick #(.DIV(RX_DIV)) u_rx_tick (
      .clk   (clk),
      .reset (reset),
      .clear (rx_clear),
      .tick  (rx_tick)
   );

   uart8_baud_tick #(.DIV(TX_DIV)) u_tx_tick (
      .clk   (clk),
      .reset (reset),
      .clear (tx_clear),
      .tick  (tx_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync <= 2'b11;
      end else begin
         rx_sync <= {rx_sync[0], rxIn};
      end
   end

   assign line = rx_sync[1];

`ifdef RX_MAJORITY_VOTE_EN
   // Holds the samples from the two ticks before the decision tick.
   logic [1:0] vote_hist;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vote_hist <= 2'b11;
      end else if (rx_tick) begin
         vote_hist <= {vote_hist[0], line};
      end
   end

   assign bit_value = (vote_hist[1] & vote_hist[0]) | (vote_hist[1] & line) | (vote_hist[0] & line);
`else
   assign bit_value = line;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state <= RX_IDLE;
      end else begin
         rx_state <= rx_next;
      end
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE: begin
            if (rx_tick && !line) rx_next = RX_START;
         end
         RX_START: begin
            if (rx_tick) begin
               if (sample_count == DECIDE_SAMPLE && bit_value) rx_next = RX_IDLE;
               else if (sample_count == LAST_SAMPLE) rx_next = RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_tick && sample_count == LAST_SAMPLE && bit_index == 3'd7) rx_next = RX_STOP;
         end
         RX_STOP: begin
            if (rx_tick && sample_count == DECIDE_SAMPLE) rx_next = bit_value ? RX_IDLE : RX_WAIT_HIGH;
         end
         RX_WAIT_HIGH: begin
            if (rx_tick && line) rx_next = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
      if (!rxEn) rx_next = RX_IDLE;
   end

   always_comb begin
      rxBusy = (rx_state == RX_START) || (rx_state == RX_DATA) || (rx_state == RX_STOP);
      rxDone = rx_done_q;
      rxErr  = rx_err_q;
      rxOut  = rx_out_q;
   end

   assign rx_clear = (rx_state == RX_IDLE) && (rx_next != RX_IDLE);

   // Pulses are gated by rxEn so a disable on the deciding tick drops the frame silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_count <= '0;
         bit_index    <= '0;
         shadow       <= '0;
         rx_out_q     <= '0;
         rx_done_q    <= 1'b0;
         rx_err_q     <= 1'b0;
      end else begin
         rx_done_q <= 1'b0;
         rx_err_q  <= 1'b0;
         if (rx_state == RX_IDLE) begin
            sample_count <= '0;
            bit_index    <= '0;
         end else if (rx_tick) begin
            sample_count <= sample_count + 1'b1;
         end
         if (rx_state == RX_DATA && rx_tick && sample_count == LAST_SAMPLE) begin
            bit_index <= bit_index + 1'b1;
         end
         if (rxEn && rx_tick && sample_count == DECIDE_SAMPLE) begin
            case (rx_state)
               RX_DATA: shadow <= {bit_value, shadow[7:1]};
               RX_STOP: begin
                  if (bit_value) begin
                     rx_out_q  <= shadow;
                     rx_done_q <= 1'b1;
                  end else begin
                     rx_err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
      end else begin
         tx_state <= tx_next;
      end
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (txStart) tx_next = TX_START;
         TX_START: if (tx_tick) tx_next = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bit_index == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
      if (!txEn) tx_next = TX_IDLE;
   end

   always_comb begin
      txBusy = 1'b1;
      txOut  = 1'b1;
      case (tx_state)
         TX_IDLE:  txBusy = 1'b0;
         TX_START: txOut  = 1'b0;
         TX_DATA:  txOut  = tx_shift[0];
         TX_STOP:  txOut  = 1'b1;
         default:  txBusy = 1'b0;
      endcase
      txDone = tx_done_q;
   end

   assign tx_clear = (tx_state == TX_IDLE) && (tx_next != TX_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_shift     <= '0;
         tx_bit_index <= '0;
         tx_done_q    <= 1'b0;
      end else begin
         tx_done_q <= (tx_state == TX_STOP) && tx_tick && txEn;
         if (tx_state == TX_IDLE) begin
            tx_bit_index <= '0;
            if (txStart && txEn) tx_shift <= txIn;
         end else if (tx_state == TX_DATA && tx_tick) begin
            tx_shift     <= tx_shift >> 1;
            tx_bit_index <= tx_bit_index + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart8_rxtx.sv
// Directed testbench for uart8_rxtx at 12 MHz / 9600 baud: rx frames, false start, framing error, stop glitch, tx frame and aborts.
`timescale 1ns/1ps

module tb_uart8_rxtx;

   localparam int BIT_CLKS = 1250;
   localparam int RX_DIV = 78;
   // Stop-bit decision tick: 16 start ticks + 128 data ticks + 8 ticks into the stop bit.
   localparam int STOP_SAMPLE_CLKS = (16 + 8 * 16 + 8) * RX_DIV;
   localparam int SYNC_LAG = 3;
   localparam int GLITCH_HALF = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxEn;
   logic       rxIn;
   logic       rxBusy;
   logic       rxDone;
   logic       rxErr;
   logic [7:0] rxOut;
   logic       txEn;
   logic       txStart;
   logic [7:0] txIn;
   logic       txBusy;
   logic       txDone;
   logic       txOut;

   int   assertCount = 0;
   int   failCount = 0;
   int   cycle = 0;
   int   rxDoneCount = 0;
   int   rxErrCount = 0;
   int   txDoneCount = 0;
   int   lastBusyRise = -1;
   logic rxBusyPrev = 1'b0;
   int   frameStart = 0;

   uart8_rxtx dut (
      .clk     (clk),
      .reset   (reset),
      .rxEn    (rxEn),
      .rxIn    (rxIn),
      .rxBusy  (rxBusy),
      .rxDone  (rxDone),
      .rxErr   (rxErr),
      .rxOut   (rxOut),
      .txEn    (txEn),
      .txStart (txStart),
      .txIn    (txIn),
      .txBusy  (txBusy),
      .txDone  (txDone),
      .txOut   (txOut)
   );

   always #41.667 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Pulse counters and rxBusy rising-edge timestamp, sampled away from the active edge.
   always @(negedge clk) begin
      if (rxDone === 1'b1) rxDoneCount++;
      if (rxErr === 1'b1) rxErrCount++;
      if (txDone === 1'b1) txDoneCount++;
      if (rxBusy === 1'b1 && rxBusyPrev !== 1'b1) lastBusyRise = cycle;
      rxBusyPrev = rxBusy;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame on rxIn; optionally pulls the line low for a short window around the stop-bit decision.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit glitch);
      logic [9:0] frame;
      int         center;
      logic       v;
      frame      = {stopBit, data, 1'b0};
      frameStart = cycle;
      center     = -1;
      for (int c = 0; c < 10 * BIT_CLKS; c++) begin
         v = frame[c / BIT_CLKS];
         if (glitch && center < 0 && lastBusyRise > frameStart)
            center = lastBusyRise + STOP_SAMPLE_CLKS - SYNC_LAG;
         if (center >= 0 && cycle >= center - GLITCH_HALF && cycle <= center + GLITCH_HALF)
            v = 1'b0;
         rxIn = v;
         @(negedge clk);
      end
      rxIn = stopBit;
   endtask

   initial begin
      int doneBase;
      int errBase;
      int txBase;
      int busyCycles;
      logic [9:0] txFrame;

      reset   = 1'b0;
      rxEn    = 1'b0;
      rxIn    = 1'b1;
      txEn    = 1'b0;
      txStart = 1'b0;
      txIn    = 8'h00;

      idleCycles(120);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("reset_txOut", txOut, 1);
      checkOutput("reset_txBusy", txBusy, 0);
      checkOutput("reset_txDone", txDone, 0);
      checkOutput("reset_rxBusy", rxBusy, 0);
      checkOutput("reset_rxDone", rxDone, 0);
      checkOutput("reset_rxErr", rxErr, 0);
      checkOutput("reset_rxOut", rxOut, 8'h00);

      rxEn = 1'b1;
      idleCycles(200);

      doneBase = rxDoneCount;
      errBase  = rxErrCount;
      applyStimulus(8'h55, 1'b1, 1'b0);
      idleCycles(200);
      checkOutput("rx55_busy_rise", (lastBusyRise > frameStart) && (lastBusyRise - frameStart <= 100), 1);
      checkOutput("rx55_done_count", rxDoneCount - doneBase, 1);
      checkOutput("rx55_err_count", rxErrCount - errBase, 0);
      checkOutput("rx55_rxOut", rxOut, 8'h55);
      checkOutput("rx55_busy_after", rxBusy, 0);

      doneBase   = rxDoneCount;
      errBase    = rxErrCount;
      frameStart = cycle;
      rxIn = 1'b0;
      idleCycles(360);
      rxIn = 1'b1;
      idleCycles(1300);
      checkOutput("false_start_seen", lastBusyRise > frameStart, 1);
      checkOutput("false_start_busy", rxBusy, 0);
      checkOutput("false_start_done", rxDoneCount - doneBase, 0);
      checkOutput("false_start_err", rxErrCount - errBase, 0);

      doneBase = rxDoneCount;
      errBase  = rxErrCount;
      applyStimulus(8'hA3, 1'b0, 1'b0);
      idleCycles(1500);
      checkOutput("stop_low_err", rxErrCount - errBase, 1);
      checkOutput("stop_low_done", rxDoneCount - doneBase, 0);
      checkOutput("stop_low_rxOut", rxOut, 8'h55);
      checkOutput("stop_low_busy", rxBusy, 0);
      rxIn = 1'b1;
      idleCycles(300);
      checkOutput("stop_low_recover_done", rxDoneCount - doneBase, 0);
      errBase = rxErrCount;
      applyStimulus(8'h5A, 1'b1, 1'b0);
      idleCycles(200);
      checkOutput("rx5a_done_count", rxDoneCount - doneBase, 1);
      checkOutput("rx5a_err_count", rxErrCount - errBase, 0);
      checkOutput("rx5a_rxOut", rxOut, 8'h5A);

      doneBase = rxDoneCount;
      errBase  = rxErrCount;
      applyStimulus(8'h96, 1'b1, 1'b1);
      idleCycles(300);
`ifdef RX_MAJORITY_VOTE_EN
      checkOutput("glitch_done", rxDoneCount - doneBase, 1);
      checkOutput("glitch_err", rxErrCount - errBase, 0);
      checkOutput("glitch_rxOut", rxOut, 8'h96);
`else
      checkOutput("glitch_done", rxDoneCount - doneBase, 0);
      checkOutput("glitch_err", rxErrCount - errBase, 1);
      checkOutput("glitch_rxOut", rxOut, 8'h5A);
`endif

      doneBase = rxDoneCount;
      errBase  = rxErrCount;
      rxIn = 1'b0;
      idleCycles(3000);
      checkOutput("rx_abort_busy_before", rxBusy, 1);
      rxEn = 1'b0;
      rxIn = 1'b1;
      @(negedge clk);
      checkOutput("rx_abort_busy_after", rxBusy, 0);
      rxEn = 1'b1;
      idleCycles(1500);
      checkOutput("rx_abort_done", rxDoneCount - doneBase, 0);
      checkOutput("rx_abort_err", rxErrCount - errBase, 0);

      txEn = 1'b1;
      idleCycles(10);
      txBase     = txDoneCount;
      busyCycles = 0;
      txFrame    = {1'b1, 8'h3C, 1'b0};
      txIn    = 8'h3C;
      txStart = 1'b1;
      for (int c = 1; c <= 12600; c++) begin
         @(negedge clk);
         if (c == 1) txStart = 1'b0;
         if (c == 5000) begin
            txIn    = 8'hFF;
            txStart = 1'b1;
         end
         if (c == 5001) txStart = 1'b0;
         if (txBusy === 1'b1) busyCycles++;
         if (c <= 10 * BIT_CLKS && (c - 1) % BIT_CLKS == BIT_CLKS / 2)
            checkOutput($sformatf("tx_bit%0d", (c - 1) / BIT_CLKS), txOut, txFrame[(c - 1) / BIT_CLKS]);
      end
      checkOutput("tx_done_count", txDoneCount - txBase, 1);
      checkOutput("tx_busy_cycles", busyCycles, 12500);
      checkOutput("tx_idle_txOut", txOut, 1);
      checkOutput("tx_idle_busy", txBusy, 0);

      txBase  = txDoneCount;
      txIn    = 8'h00;
      txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
      idleCycles(3000);
      checkOutput("tx_abort_mid_txOut", txOut, 0);
      txEn = 1'b0;
      @(negedge clk);
      checkOutput("tx_abort_txOut", txOut, 1);
      checkOutput("tx_abort_busy", txBusy, 0);
      txEn = 1'b1;
      idleCycles(10000);
      checkOutput("tx_abort_done", txDoneCount - txBase, 0);
      checkOutput("tx_abort_busy_later", txBusy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
